mat_result_serializer: RTL
==========================

// Module: mat_result_serializer
// PURPOSE
//  Downstream stage of mat_mul. Accepts one ROWS x COLS result matrix in a single
//  valid/ready handshake and streams its elements one per beat, row-major, on a
//  valid/ready stream with a last flag. mat_mul.out_valid connects to in_valid.
//  in_ready connects to mat_mul.out_ready.
// PARAMETERS
//  DATA_WIDTH  32  element width in bits
//  ROWS        3   result rows (= mat_mul ROWS_A), >= 1
//  COLS        1   result cols (= mat_mul COLS_B), >= 1
//  RW = max(1,$clog2(ROWS)), CW = max(1,$clog2(COLS))   (localparams)
// PORTS
//  clk       in   1                    single clock, rising edge
//  rst       in   1                    asynchronous reset, active-high
//  in_valid  in   1                    result matrix c valid
//  in_ready  out  1                    serializer can capture c
//  c         in   DW x [ROWS][COLS]    result matrix, unpacked [0:ROWS-1][0:COLS-1]
//  m_valid   out  1                    output beat valid
//  m_ready   in   1                    downstream accepts beat
//  m_data    out  DATA_WIDTH           element (or checksum, see CONFIGURATION)
//  m_row     out  RW                   row index of current beat
//  m_col     out  CW                   col index of current beat
//  m_last    out  1                    final beat of the matrix
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, m_valid=0,
//    m_last=0, m_row=0, m_col=0, m_data=0, buffer and checksum accumulator=0.
//  - FSM states: IDLE, STREAM (and CSUM when the macro is defined).
//  - IDLE: in_ready=1, m_valid=0. When in_valid & in_ready, capture all of c into
//    the internal buffer and set row=col=0. Go to STREAM.
//  - STREAM: in_ready=0, m_valid=1. m_data=buf[row][col]. A beat transfers on
//    m_valid & m_ready. On transfer, col increments. When col wraps from COLS-1 to 0,
//    row increments. m_last=1 only at row=ROWS-1, col=COLS-1.
//  - Last element transferred: go to IDLE (to CSUM when the macro is defined).
//  - Latency: capture edge -> m_valid high the next cycle. With m_ready held at 1,
//    1 beat/cycle. in_ready rises the cycle after the final beat transfers (no
//    same-cycle recapture). Minimum period: ROWS*COLS+1 cycles per matrix.
//  - Stability: while m_valid=1 & m_ready=0, m_data/m_row/m_col/m_last hold.
//    m_valid never drops before the transfer.
//  - in_valid in STREAM is ignored. c changes after capture do not affect output.
//  - ROWS=COLS=1: single beat with m_last=1.
//  - rst mid-stream: the matrix is dropped immediately and no further beats are
//    produced. After release, state is IDLE.
//  - m_data outputs are registered-stable. No combinational path from m_ready to
//    m_data. m_valid and in_ready are decoded from the state register.
// CONFIGURATION
//  MAT_SER_CHECKSUM_EN defined:
//    - The accumulator clears on capture. It adds each transferred element
//      modulo 2^DATA_WIDTH (carry discarded).
//    - After the last element, state CSUM emits one extra beat with
//      m_data = accumulator, m_row=0, m_col=0, m_last=1.
//    - In this mode m_last is 0 on the final element beat.
//    - After the checksum transfers: go to IDLE.
//    - Period becomes ROWS*COLS+2 cycles.
//  MAT_SER_CHECKSUM_EN undefined: no CSUM state and no accumulator. m_last is on
//    the final element.
// TESTING
//  1. ROWS=3,COLS=1, c={5,7,2}, m_ready=1
//     -> beats 5,7,2 on 3 consecutive cycles after capture.
//     -> m_last only on 2. in_ready=1 the following cycle.
//  2. Same input, m_ready toggles 1,0,0,1,1
//     -> outputs hold during stalls and the sequence is 5,7,2 unchanged.
//     -> c is overwritten with {9,9,9} after capture; output is still 5,7,2.
//  3. Two matrices back-to-back with in_valid held high
//     -> second capture occurs exactly 1 cycle after the first's last beat.
//     -> no element is lost or duplicated.
//  4. Assert rst after the 2nd beat of {5,7,2}
//     -> m_valid=0 and in_ready=1 immediately.
//     -> the next matrix {1,1,1} streams 1,1,1 from row 0.
//  5. CHECKSUM_EN, c={32'hFFFF_FFFF,1,2}
//     -> beats FFFF_FFFF,1,2, then checksum 32'h0000_0002 with m_last.
//  6. ROWS=2,COLS=2, c={{1,2},{3,4}}
//     -> (row,col) sequence (0,0)(0,1)(1,0)(1,1), data 1,2,3,4, m_last on 4.

Source files
------------

// File: rtl/mat_result_serializer.sv
// Captures a ROWS x COLS result matrix in one handshake and streams it row-major,
// one element per beat. Optional trailing checksum beat: define MAT_SER_CHECKSUM_EN.
module mat_result_serializer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROWS       = 3,
    parameter int unsigned COLS       = 1,
    localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW        = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] c [0:ROWS-1][0:COLS-1],
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [RW-1:0]         m_row,
    output logic [CW-1:0]         m_col,
    output logic                  m_last
);

`ifdef MAT_SER_CHECKSUM_EN
    localparam bit LAST_ON_ELEM = 1'b0;
    typedef enum logic [1:0] {IDLE, STREAM, CSUM} state_t;
`else
    localparam bit LAST_ON_ELEM = 1'b1;
    typedef enum logic {IDLE, STREAM} state_t;
`endif

    localparam bit SINGLE = (ROWS == 1) && (COLS == 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] mat_q [0:ROWS-1][0:COLS-1];
`ifdef MAT_SER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] acc;
`endif

    logic                  col_wrap;
    logic                  at_last;
    logic [RW-1:0]         nxt_row;
    logic [CW-1:0]         nxt_col;
    logic                  nxt_last;
    logic [DATA_WIDTH-1:0] nxt_data;

    assign in_ready = (state == IDLE);
    assign m_valid  = (state != IDLE);

    // Row-major successor of the current beat; the index is held in range on the final element.
    always_comb begin
        col_wrap = (m_col == CW'(COLS - 1));
        at_last  = col_wrap && (m_row == RW'(ROWS - 1));
        nxt_col  = col_wrap ? '0 : m_col + CW'(1);
        nxt_row  = col_wrap ? m_row + RW'(1) : m_row;
        if (at_last) begin
            nxt_row = '0;
        end
        nxt_last = LAST_ON_ELEM && (nxt_row == RW'(ROWS - 1)) && (nxt_col == CW'(COLS - 1));
        nxt_data = mat_q[nxt_row][nxt_col];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            m_data <= '0;
            m_row  <= '0;
            m_col  <= '0;
            m_last <= 1'b0;
            for (int r = 0; r < int'(ROWS); r++) begin
                for (int k = 0; k < int'(COLS); k++) begin
                    mat_q[r][k] <= '0;
                end
            end
`ifdef MAT_SER_CHECKSUM_EN
            acc    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int r = 0; r < int'(ROWS); r++) begin
                            for (int k = 0; k < int'(COLS); k++) begin
                                mat_q[r][k] <= c[r][k];
                            end
                        end
                        m_data <= c[0][0];
                        m_row  <= '0;
                        m_col  <= '0;
                        m_last <= LAST_ON_ELEM && SINGLE;
`ifdef MAT_SER_CHECKSUM_EN
                        acc    <= '0;
`endif
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (m_ready) begin
`ifdef MAT_SER_CHECKSUM_EN
                        acc <= acc + m_data;
`endif
                        if (at_last) begin
                            m_row <= '0;
                            m_col <= '0;
`ifdef MAT_SER_CHECKSUM_EN
                            // Checksum beat carries the running sum including this final element.
                            m_data <= acc + m_data;
                            m_last <= 1'b1;
                            state  <= CSUM;
`else
                            m_last <= 1'b0;
                            state  <= IDLE;
`endif
                        end else begin
                            m_data <= nxt_data;
                            m_row  <= nxt_row;
                            m_col  <= nxt_col;
                            m_last <= nxt_last;
                        end
                    end
                end
`ifdef MAT_SER_CHECKSUM_EN
                CSUM: begin
                    if (m_ready) begin
                        m_last <= 1'b0;
                        state  <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
